// File: rtl/atm_txn_ctrl.sv
// atm_txn_ctrl: ATM transaction sequencer (PIN, mode, amount, check, single inc/dec strobe).
// Rev 1.0
`default_nettype none

module atm_txn_ctrl #(
  parameter logic [5:0]  PIN_CODE    = 6'b101101,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned TIMEOUT_CYC = 500_000_000,
  parameter int unsigned DONE_CYC    = 100_000_000,
  parameter int unsigned TMR_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [5:0] sw,
  input  logic [7:0] balance,
  output logic [7:0] amount,
  output logic       inc,
  output logic       dec,
  output logic [3:0] state_code,
  output logic       err_led,
  output logic       lock_led,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_PIN    = 4'd1,
    S_MENU   = 4'd2,
    S_AMOUNT = 4'd3,
    S_CHECK  = 4'd4,
    S_COMMIT = 4'd5,
    S_DONE   = 4'd6,
    S_ERROR  = 4'd7,
    S_LOCK   = 4'd8
  } state_t;

  localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(DONE_CYC - 1);
  localparam logic [2:0]       TRIES     = 3'(MAX_TRIES);

  state_t             state_q, state_d;
  logic [7:0]         amount_q, amount_d;
  logic               mode_q, mode_d;  // 0 = deposit, 1 = withdraw
  logic [2:0]         fail_q, fail_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               up_q, dn_q;
  logic               inc_q, dec_q, err_q, lock_q, busy_q;
  logic               up_raw, dn_raw, up_ev, dn_ev;
  logic               tmr_clr, err_pulse;

  // Simultaneous rising edges cancel each other out.
  assign up_raw = btn_up & ~up_q;
  assign dn_raw = btn_down & ~dn_q;
  assign up_ev  = up_raw & ~dn_raw;
  assign dn_ev  = dn_raw & ~up_raw;

  always_comb begin
    state_d   = state_q;
    amount_d  = amount_q;
    mode_d    = mode_q;
    fail_d    = fail_q;
    tmr_clr   = 1'b0;
    err_pulse = 1'b0;
    case (state_q)
      S_IDLE: if (up_ev) state_d = S_PIN;
      S_PIN: begin
        if (up_ev) begin
          tmr_clr = 1'b1;
          if (sw == PIN_CODE) begin
            state_d = S_MENU;
            fail_d  = 3'd0;
          end else begin
            fail_d    = fail_q + 3'd1;
            err_pulse = 1'b1;
            if (fail_d == TRIES) state_d = S_LOCK;
          end
        end else if (dn_ev || tmr_q == TO_LAST) begin
          state_d = S_IDLE;
        end
      end
      S_MENU: begin
        if (up_ev || dn_ev) begin
          state_d = S_AMOUNT;
          mode_d  = dn_ev;
        end else if (tmr_q == TO_LAST) begin
          state_d = S_IDLE;
        end
      end
      S_AMOUNT: begin
        if (up_ev) begin
          amount_d = {2'b00, sw};
          state_d  = S_CHECK;
        end else if (dn_ev || tmr_q == TO_LAST) begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (amount_q == 8'd0)
          state_d = S_ERROR;
        else if (!mode_q && ({1'b0, balance} + {1'b0, amount_q} > 9'd255))
          state_d = S_ERROR;
        else if (mode_q && (amount_q > balance))
          state_d = S_ERROR;
        else
          state_d = S_COMMIT;
      end
      S_COMMIT: state_d = S_DONE;
      S_DONE:   if (tmr_q == HOLD_LAST) state_d = S_IDLE;
      S_ERROR:  if (tmr_q == HOLD_LAST) state_d = S_MENU;
      S_LOCK:   state_d = S_LOCK;
      default:  state_d = S_IDLE;
    endcase

    if (state_d != state_q || tmr_clr)
      tmr_d = '0;
    else if (tmr_q != '1)
      tmr_d = tmr_q + 1'b1;
    else
      tmr_d = tmr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      amount_q <= 8'd0;
      mode_q   <= 1'b0;
      fail_q   <= 3'd0;
      tmr_q    <= '0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      err_q    <= 1'b0;
      lock_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      amount_q <= amount_d;
      mode_q   <= mode_d;
      fail_q   <= fail_d;
      tmr_q    <= tmr_d;
      up_q     <= btn_up;
      dn_q     <= btn_down;
      inc_q    <= (state_d == S_COMMIT) && !mode_d;
      dec_q    <= (state_d == S_COMMIT) && mode_d;
      err_q    <= (state_d == S_ERROR) || err_pulse;
      lock_q   <= (state_d == S_LOCK);
      busy_q   <= (state_d != S_IDLE) && (state_d != S_LOCK);
    end
  end

  assign amount     = amount_q;
  assign inc        = inc_q;
  assign dec        = dec_q;
  assign state_code = state_q;
  assign err_led    = err_q;
  assign lock_led   = lock_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_atm_txn_ctrl.sv
// tb_atm_txn_ctrl: scoreboard-based bench for atm_txn_ctrl.
// Rev 1.0
`default_nettype none

module tb_atm_txn_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [5:0] sw = 6'd0;
  logic [7:0] balance = 8'd0;
  logic [7:0] amount;
  logic       inc, dec, err_led, lock_led, busy;
  logic [3:0] state_code;

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] exp_q[$];  // {is_withdraw, amount}

  atm_txn_ctrl #(
    .PIN_CODE(6'b101101), .MAX_TRIES(3), .TIMEOUT_CYC(20), .DONE_CYC(4), .TMR_W(32)
  ) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .sw(sw),
    .balance(balance), .amount(amount), .inc(inc), .dec(dec),
    .state_code(state_code), .err_led(err_led), .lock_led(lock_led), .busy(busy)
  );

  always #5 clk = ~clk;

  // Every strobe must match the next scoreboard entry; none may appear unannounced.
  always @(negedge clk) begin
    if (inc || dec) begin
      n_cmp++;
      if (inc && dec) begin
        n_bad++; $display("FAIL strobe_excl: inc=%0b dec=%0b, required not both", inc, dec);
      end else if (exp_q.size() == 0) begin
        n_bad++; $display("FAIL strobe_unexp: inc=%0b dec=%0b amount=%0d, required no strobe", inc, dec, amount);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({dec, amount} !== e) begin
          n_bad++; $display("FAIL strobe_val: got dec=%0b amt=%0d, required dec=%0b amt=%0d", dec, amount, e[8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic press_up();
    btn_up = 1'b1; step(); btn_up = 1'b0; step();
  endtask

  task automatic press_dn();
    btn_down = 1'b1; step(); btn_down = 1'b0; step();
  endtask

  task automatic do_reset();
    rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0; step(); step(); rst = 1'b0;
  endtask

  task automatic count_state(input logic [3:0] s, output int n);
    n = 0;
    while (state_code == s && n < 50) begin n++; step(); end
  endtask

  task automatic login();
    press_up(); sw = 6'd45; press_up();
    n_cmp++;
    if (state_code !== 4'd2) begin
      n_bad++; $display("FAIL login: state=%0d, required 2", state_code);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({state_code, amount, inc, dec, err_led, lock_led, busy} !== 17'd0) begin
      n_bad++; $display("FAIL reset: st=%0d amt=%0d inc=%0b dec=%0b err=%0b lock=%0b busy=%0b, required all 0",
                        state_code, amount, inc, dec, err_led, lock_led, busy);
    end
  endtask

  task automatic test_deposit();
    int n;
    do_reset(); balance = 8'd10;
    login(); press_up();
    sw = 6'd20; btn_up = 1'b1; exp_q.push_back({1'b0, 8'd20}); step(); btn_up = 1'b0;
    n_cmp++;
    if (state_code !== 4'd4 || inc !== 1'b0) begin
      n_bad++; $display("FAIL dep_check: st=%0d inc=%0b, required 4/0", state_code, inc);
    end
    step();
    n_cmp++;
    if (state_code !== 4'd5 || inc !== 1'b1 || dec !== 1'b0 || amount !== 8'd20) begin
      n_bad++; $display("FAIL dep_commit: st=%0d inc=%0b dec=%0b amt=%0d, required 5/1/0/20", state_code, inc, dec, amount);
    end
    step();
    n_cmp++;
    if (inc !== 1'b0 || amount !== 8'd20) begin
      n_bad++; $display("FAIL dep_one_cycle: inc=%0b amt=%0d, required 0/20", inc, amount);
    end
    count_state(4'd6, n);
    n_cmp++;
    if (n != 4 || state_code !== 4'd0) begin
      n_bad++; $display("FAIL dep_done: cycles=%0d st=%0d, required 4/0", n, state_code);
    end
  endtask

  task automatic test_withdraw();
    int n;
    do_reset(); balance = 8'd20;
    login(); press_dn();
    sw = 6'd20; exp_q.push_back({1'b1, 8'd20}); press_up();
    n_cmp++;
    if (state_code !== 4'd5 || dec !== 1'b1 || inc !== 1'b0) begin
      n_bad++; $display("FAIL wd_equal: st=%0d dec=%0b inc=%0b, required 5/1/0", state_code, dec, inc);
    end
    step(); count_state(4'd6, n);
    login(); press_dn(); sw = 6'd21; press_up();
    n_cmp++;
    if (state_code !== 4'd7 || err_led !== 1'b1) begin
      n_bad++; $display("FAIL wd_over: st=%0d err=%0b, required 7/1", state_code, err_led);
    end
    count_state(4'd7, n);
    n_cmp++;
    if (n != 4 || state_code !== 4'd2 || err_led !== 1'b0) begin
      n_bad++; $display("FAIL wd_err_hold: cycles=%0d st=%0d err=%0b, required 4/2/0", n, state_code, err_led);
    end
  endtask

  task automatic test_overflow();
    int n;
    do_reset(); balance = 8'd250;
    login(); press_up(); sw = 6'd6; press_up();
    n_cmp++;
    if (state_code !== 4'd7) begin
      n_bad++; $display("FAIL ovf_256: st=%0d, required 7", state_code);
    end
    count_state(4'd7, n);
    press_up(); sw = 6'd5; exp_q.push_back({1'b0, 8'd5}); press_up();
    n_cmp++;
    if (state_code !== 4'd5 || inc !== 1'b1 || amount !== 8'd5) begin
      n_bad++; $display("FAIL ovf_255: st=%0d inc=%0b amt=%0d, required 5/1/5", state_code, inc, amount);
    end
    step(); count_state(4'd6, n);
    login(); press_up(); sw = 6'd0; press_up();
    n_cmp++;
    if (state_code !== 4'd7) begin
      n_bad++; $display("FAIL amt_zero: st=%0d, required 7", state_code);
    end
    count_state(4'd7, n);
  endtask

  task automatic test_lockout();
    do_reset(); press_up(); sw = 6'd0;
    for (int i = 0; i < 3; i++) begin
      btn_up = 1'b1; step(); btn_up = 1'b0;
      n_cmp++;
      if (err_led !== 1'b1) begin
        n_bad++; $display("FAIL lock_errpulse%0d: err=%0b, required 1", i, err_led);
      end
      step();
      n_cmp++;
      if (err_led !== 1'b0) begin
        n_bad++; $display("FAIL lock_errclr%0d: err=%0b, required 0", i, err_led);
      end
    end
    n_cmp++;
    if (state_code !== 4'd8 || lock_led !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL lock_enter: st=%0d lock=%0b busy=%0b, required 8/1/0", state_code, lock_led, busy);
    end
    press_up(); press_dn(); sw = 6'd45; press_up();
    n_cmp++;
    if (state_code !== 4'd8 || lock_led !== 1'b1) begin
      n_bad++; $display("FAIL lock_hold: st=%0d lock=%0b, required 8/1", state_code, lock_led);
    end
    do_reset();
    n_cmp++;
    if (state_code !== 4'd0 || lock_led !== 1'b0) begin
      n_bad++; $display("FAIL lock_rst: st=%0d lock=%0b, required 0/0", state_code, lock_led);
    end
    // Two misses then the right PIN clears the count; two more misses must not lock.
    press_up(); sw = 6'd0; press_up(); press_up(); sw = 6'd45; press_up();
    n_cmp++;
    if (state_code !== 4'd2) begin
      n_bad++; $display("FAIL pin_recover: st=%0d, required 2", state_code);
    end
    press_dn(); press_dn(); press_up(); sw = 6'd0; press_up(); press_up();
    n_cmp++;
    if (state_code !== 4'd1) begin
      n_bad++; $display("FAIL fail_cleared: st=%0d, required 1", state_code);
    end
    // A cancel keeps the count, so one more miss after re-entry locks.
    press_dn(); press_up(); press_up();
    n_cmp++;
    if (state_code !== 4'd8) begin
      n_bad++; $display("FAIL fail_kept: st=%0d, required 8", state_code);
    end
  endtask

  task automatic test_timeout_cancel();
    int n;
    do_reset(); balance = 8'd50;
    login(); btn_up = 1'b1; step(); btn_up = 1'b0;
    count_state(4'd3, n);
    n_cmp++;
    if (n != 20 || state_code !== 4'd0) begin
      n_bad++; $display("FAIL timeout: cycles=%0d st=%0d, required 20/0", n, state_code);
    end
    press_up(); press_dn();
    n_cmp++;
    if (state_code !== 4'd0) begin
      n_bad++; $display("FAIL pin_cancel: st=%0d, required 0", state_code);
    end
    login(); btn_up = 1'b1; btn_down = 1'b1; step(); btn_up = 1'b0; btn_down = 1'b0; step();
    n_cmp++;
    if (state_code !== 4'd2) begin
      n_bad++; $display("FAIL simul_btn: st=%0d, required 2", state_code);
    end
    press_dn(); press_dn();
    n_cmp++;
    if (state_code !== 4'd0) begin
      n_bad++; $display("FAIL amt_cancel: st=%0d, required 0", state_code);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(); balance = 8'd100;
    login(); press_up(); sw = 6'd9; btn_up = 1'b1; step();
    n_cmp++;
    if (state_code !== 4'd4) begin
      n_bad++; $display("FAIL mid_check: st=%0d, required 4", state_code);
    end
    rst = 1'b1; btn_up = 1'b0; step();
    n_cmp++;
    if (state_code !== 4'd0 || inc !== 1'b0 || dec !== 1'b0 || amount !== 8'd0) begin
      n_bad++; $display("FAIL mid_rst: st=%0d inc=%0b dec=%0b amt=%0d, required 0/0/0/0", state_code, inc, dec, amount);
    end
    rst = 1'b0; step(); step();
    n_cmp++;
    if (state_code !== 4'd0 || inc !== 1'b0) begin
      n_bad++; $display("FAIL mid_after: st=%0d inc=%0b, required 0/0", state_code, inc);
    end
  endtask

  initial begin
    test_reset();
    test_deposit();
    test_withdraw();
    test_overflow();
    test_lockout();
    test_timeout_cancel();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL sb_empty: %0d strobes outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/atm_txn_ctrl.md
Name: atm_txn_ctrl

Overview:
- Transaction sequencer for the ATM balance datapath: steps the user through PIN entry, deposit/withdraw selection, amount entry and validation.
- Issues a single inc or dec strobe with a latched amount to the balance counter.
- Sits between the debounced push-button pulses and the balance counter. Adds wrong-PIN lockout and inactivity timeout.

Parameters:
- PIN_CODE, 6'b101101, PIN compared against sw[5:0].
- MAX_TRIES, 3, consecutive wrong PINs before lockout (1..7).
- TIMEOUT_CYC, 500_000_000, inactivity cycles in PIN/MENU/AMOUNT before abort.
- DONE_CYC, 100_000_000, cycles DONE/ERROR status is held.
- TMR_W, 32, width of the shared timer.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- btn_up, input, 1, debounced level, up button.
- btn_down, input, 1, debounced level, down button.
- sw, input, 6, PIN / amount switches.
- balance, input, 8, current balance from the balance counter.
- amount, output, 8, latched transaction amount to the counter.
- inc, output, 1, one-cycle deposit strobe.
- dec, output, 1, one-cycle withdraw strobe.
- state_code, output, 4, current state encoding, for display.
- err_led, output, 1, high in ERROR and for one cycle on a wrong PIN.
- lock_led, output, 1, high in LOCK.
- busy, output, 1, high in any state except IDLE and LOCK.

Behaviour:
- Edge detect: registered copies of btn_up and btn_down.
  - up_ev = btn_up & ~btn_up_q; dn_ev likewise.
  - If up_ev and dn_ev occur in the same cycle, both are discarded (no event).
- Reset: state=IDLE, amount=0, inc=dec=0, err_led=lock_led=busy=0, fail_cnt=0, timer=0, mode=0, state_code=0.
- State encodings: IDLE=0, PIN=1, MENU=2, AMOUNT=3, CHECK=4, COMMIT=5, DONE=6, ERROR=7, LOCK=8.
- IDLE: up_ev -> PIN. dn_ev ignored.
- PIN:
  - up_ev with sw==PIN_CODE -> MENU, fail_cnt=0.
  - up_ev with mismatch: fail_cnt+1, err_led pulses 1 cycle. If the new fail_cnt==MAX_TRIES -> LOCK, else stay in PIN.
  - dn_ev -> IDLE (cancel). fail_cnt is kept.
- MENU: up_ev -> AMOUNT with mode=deposit; dn_ev -> AMOUNT with mode=withdraw.
- AMOUNT:
  - up_ev: amount <= {2'b00, sw} -> CHECK.
  - dn_ev -> IDLE (cancel), amount unchanged.
- CHECK (exactly 1 cycle, evaluated in priority order):
  - amount==0 -> ERROR.
  - deposit and balance+amount > 255 (9-bit compare) -> ERROR.
  - withdraw and amount > balance -> ERROR.
  - otherwise -> COMMIT.
  - amount == balance on withdraw is legal. balance+amount == 255 on deposit is legal.
- COMMIT (exactly 1 cycle): inc=1 for deposit or dec=1 for withdraw. amount is stable while the strobe is high and stays held after it. Next state DONE.
  - inc and dec are never high together, and never high outside COMMIT.
- DONE: hold for DONE_CYC cycles, then IDLE. Events are ignored.
- ERROR: err_led=1. Hold for DONE_CYC cycles, then MENU (the user is still authenticated). Events are ignored.
- LOCK: lock_led=1, all events ignored. Only rst exits.
- Timer:
  - Cleared on every state change and on every accepted event.
  - In PIN/MENU/AMOUNT, reaching TIMEOUT_CYC-1 -> IDLE on the next edge.
  - In DONE/ERROR it counts the DONE_CYC hold.
  - Saturates, never wraps.
- Latency: up_ev in AMOUNT -> strobe 2 cycles later (CHECK, then COMMIT).
- rst asserted in any state, including COMMIT, wins. No strobe is issued in the reset cycle or after it.

Test Plan:
Bench overrides TIMEOUT_CYC=20, DONE_CYC=4, PIN_CODE=6'b101101, MAX_TRIES=3.
- Deposit: balance=10. up, sw=45 + up, up (deposit), sw=20 + up -> amount=20; inc high exactly 1 cycle, 2 cycles after the last up_ev; dec=0; DONE for 4 cycles, then IDLE.
- Withdraw boundaries: balance=20. Withdraw 20 -> dec pulse. Then balance=20, withdraw 21 -> ERROR for 4 cycles, no strobe, return to MENU.
- Overflow: balance=250. Deposit 6 -> ERROR. Deposit 5 -> inc pulse. Amount 0 -> ERROR.
- Lockout: 3 wrong PINs (sw=0) -> err_led pulses 3 times, LOCK with lock_led=1; buttons are ignored; rst -> IDLE with fail_cnt=0. Also: 2 wrong PINs, then the correct PIN -> MENU with fail_cnt=0.
- Timeout/cancel: in AMOUNT with no events for 20 cycles -> IDLE, no strobe. dn_ev in PIN -> IDLE. Simultaneous up+down in MENU -> stays in MENU.
- Reset mid-op: rst asserted in the CHECK cycle -> next cycle IDLE, inc=dec=0, amount=0.
